// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the control unit and div_unit.
//   start, op, rs1_data, rs2_data, rd_address : request (control -> divider)
//   busy, done, result, wb_rd_address, wb_reg_write : status / write-back
// master = control unit side, slave = divider side.
interface div_unit_if #(
   parameter int XLEN = 64
);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_address;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      wb_rd_address;
   logic            wb_reg_write;

   modport master (
      output start, op, rs1_data, rs2_data, rd_address,
      input  busy, done, result, wb_rd_address, wb_reg_write
   );
   modport slave (
      input  start, op, rs1_data, rs2_data, rd_address,
      output busy, done, result, wb_rd_address, wb_reg_write
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : div_unit_if.slave (start/op/operands/rd in, busy/done/result/wb out)
// op: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Divide-by-zero and signed overflow
// complete in one cycle; everything else takes 64 CALC cycles plus one FIX.
module div_unit #(
   parameter int XLEN = 64
) (
   input  logic         clock,
   input  logic         reset_n,
   div_unit_if.slave    bus
);
   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic [XLEN:0]   rem;      // extra bit holds the bit shifted out of the top
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] dvs;
   logic [1:0]      op_q;
   logic [4:0]      rd_q;
   logic            q_neg;
   logic            r_neg;
   logic [XLEN-1:0] result;
   logic [4:0]      wb_rd;
   logic            done;

   // request-side decode
   logic            sgn;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] a_abs;
   logic [XLEN-1:0] b_abs;
   // iteration datapath
   logic [XLEN:0]   sh;
   logic            ge;
   // fix-up datapath
   logic [XLEN-1:0] sel;
   logic            neg;
   logic [XLEN-1:0] fix_val;

   always_comb begin
      sgn      = ~bus.op[0];
      div_zero = (bus.rs2_data == '0);
      ovf      = sgn && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_data == '1);
      a_abs    = (sgn && bus.rs1_data[XLEN-1]) ? (~bus.rs1_data + XLEN'(1)) : bus.rs1_data;
      b_abs    = (sgn && bus.rs2_data[XLEN-1]) ? (~bus.rs2_data + XLEN'(1)) : bus.rs2_data;

      sh       = {rem[XLEN-1:0], quo[XLEN-1]};
      ge       = (sh >= {1'b0, dvs});

      sel      = op_q[1] ? rem[XLEN-1:0] : quo;
      neg      = ~op_q[0] && (op_q[1] ? r_neg : q_neg);
      fix_val  = neg ? (~sel + XLEN'(1)) : sel;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         op_q   <= '0;
         rd_q   <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         result <= '0;
         wb_rd  <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q  <= bus.op;
                  rd_q  <= bus.rd_address;
                  q_neg <= bus.rs1_data[XLEN-1] ^ bus.rs2_data[XLEN-1];
                  r_neg <= bus.rs1_data[XLEN-1];
                  if (div_zero) begin
                     result <= bus.op[1] ? bus.rs1_data : '1;
                     wb_rd  <= bus.rd_address;
                     done   <= 1'b1;
                  end else if (ovf) begin
                     result <= bus.op[1] ? '0 : bus.rs1_data;
                     wb_rd  <= bus.rd_address;
                     done   <= 1'b1;
                  end else begin
                     rem   <= '0;
                     quo   <= a_abs;
                     dvs   <= b_abs;
                     cnt   <= CW'(XLEN);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= ge ? (sh - {1'b0, dvs}) : sh;
               quo <= {quo[XLEN-2:0], ge};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1))
                  state <= FIX;
            end
            FIX: begin
               result <= fix_val;
               wb_rd  <= rd_q;
               done   <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy          = (state != IDLE);
   assign bus.done          = done;
   assign bus.result        = result;
   assign bus.wb_rd_address = wb_rd;
   assign bus.wb_reg_write  = done;
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
   localparam int XLEN = 64;
   localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

   typedef struct {
      logic [1:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [4:0]      rd;
      logic [XLEN-1:0] exp;
      bit              special;
   } vec_t;

   typedef struct {
      logic [XLEN-1:0] res;
      logic [4:0]      rd;
   } sb_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   sb_t  sb[$];

   div_unit_if #(.XLEN(XLEN)) bus ();

   div_unit #(.XLEN(XLEN)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard: every done pulse must match the oldest outstanding request
   always @(negedge clock) begin
      if (reset_n && bus.done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk("result", bus.result, e.res);
            chk("wb_rd_address", 64'(bus.wb_rd_address), 64'(e.rd));
            chk("wb_reg_write", 64'(bus.wb_reg_write), 64'd1);
         end
      end
   end

   // drive at a negedge; returns at the negedge after the accepting edge
   task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [4:0] rd, input logic [XLEN-1:0] exp);
      sb_t e;
      bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_address = rd;
      e.res = exp; e.rd = rd;
      sb.push_back(e);
      @(negedge clock);
      bus.start = 1'b0;
      bus.rs1_data = {$urandom, $urandom};
      bus.rs2_data = {$urandom, $urandom};
      bus.rd_address = 5'($urandom);
   endtask

   // wait for done; checks extra cycles waited, busy cycles seen and result hold
   task automatic wait_done(input string name, input int exp_wait, input int exp_busy);
      int w = 0;
      int nb = 0;
      bit held_bad = 0;
      logic [XLEN-1:0] hold = bus.result;
      while (!bus.done && w < 200) begin
         if (bus.busy) nb++;
         if (bus.result !== hold) held_bad = 1;
         @(negedge clock);
         w++;
      end
      chk({name, "_latency"}, 64'(w), 64'(exp_wait));
      chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
      chk({name, "_result_held"}, 64'(held_bad), 64'd0);
   endtask

   vec_t vecs[$];

   initial begin
      vecs = '{
         '{DIVU, 64'd100, 64'd7, 5'd5, 64'd14, 0},
         '{REMU, 64'd100, 64'd7, 5'd5, 64'd2, 0},
         '{DIV,  -64'sd100, 64'd7, 5'd6, 64'hFFFF_FFFF_FFFF_FFF2, 0},
         '{REM,  -64'sd100, 64'd7, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0},
         '{DIV,  64'd100, -64'sd7, 5'd8, 64'hFFFF_FFFF_FFFF_FFF2, 0},
         '{REM,  64'd100, -64'sd7, 5'd9, 64'd2, 0},
         '{DIV,  -64'sd7, -64'sd2, 5'd10, 64'd3, 0},
         '{REM,  -64'sd7, -64'sd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 0},
         '{DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd12, 64'h5555_5555_5555_5555, 0},
         '{REMU, 64'd3, 64'd10, 5'd13, 64'd3, 0},
         '{DIV,  64'h8000_0000_0000_0000, 64'd1, 5'd14, 64'h8000_0000_0000_0000, 0},
         '{DIVU, 64'd5, 64'd0, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1},
         '{REM,  64'd5, 64'd0, 5'd16, 64'd5, 1},
         '{DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 64'h8000_0000_0000_0000, 1},
         '{REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd18, 64'd0, 1},
         // back-to-back into the done cycle of the special cases above
         '{DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd19, 64'hFFFF_FFFF_FFFF_FFFF, 0}
      };

      bus.start = 1'b0; bus.op = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_address = '0;
      repeat (3) @(negedge clock);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_result", bus.result, 64'd0);
      chk("rst_wb_rd", 64'(bus.wb_rd_address), 64'd0);
      chk("rst_wb_we", 64'(bus.wb_reg_write), 64'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // each issue starts at the negedge of the previous done: back-to-back throughout
      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);
         wait_done($sformatf("vec%0d", i), vecs[i].special ? 0 : 65, vecs[i].special ? 0 : 65);
      end
      @(negedge clock);
      chk("done_pulse_width", 64'(bus.done), 64'd0);

      // start while busy is ignored
      issue(DIVU, 64'd1000, 64'd10, 5'd3, 64'd100);
      repeat (10) @(negedge clock);
      bus.start = 1'b1; bus.op = DIVU; bus.rs1_data = 64'd9; bus.rs2_data = 64'd3; bus.rd_address = 5'd4;
      @(negedge clock);
      bus.start = 1'b0;
      wait_done("ignore_start", 54, 54);
      repeat (80) @(negedge clock);

      // asynchronous reset mid-division
      issue(DIVU, 64'd1000, 64'd7, 5'd9, 64'd142);
      repeat (29) @(negedge clock);
      chk("pre_reset_busy", 64'(bus.busy), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_busy", 64'(bus.busy), 64'd0);
      chk("async_done", 64'(bus.done), 64'd0);
      chk("async_result", bus.result, 64'd0);
      chk("async_wb_rd", 64'(bus.wb_rd_address), 64'd0);
      sb.delete();
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      issue(DIVU, 64'd9, 64'd3, 5'd21, 64'd3);
      wait_done("after_reset", 65, 65);

      repeat (80) @(negedge clock);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative 64-bit integer divide unit for the RV64M DIV/DIVU/REM/REMU instructions. It sits directly downstream of `register_file` and consumes `rs1_data`/`rs2_data` as dividend/divisor. It returns the quotient or remainder with a destination address and write strobe that drive the register file's `write_data`/`rd_address`/`reg_write` write-back path. A start/busy/done handshake lets the control unit stall the core while a division is in flight.

## Interface
- `XLEN`, 64, operand/result width
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only when `busy`=0
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- `rs1_data`  in  XLEN  dividend
- `rs2_data`  in  XLEN  divisor
- `rd_address`  in  5  destination register, captured with `start`
- `busy`  out  1  operation in flight; `start` ignored
- `done`  out  1  one-cycle pulse; `result` valid
- `result`  out  XLEN  quotient or remainder; held until next completion
- `wb_rd_address`  out  5  captured `rd_address`; held with `result`
- `wb_reg_write`  out  1  equals `done`; x0 suppression is left to `register_file`

## Operation
- Reset (async assert, any time, including mid-division): state IDLE, `busy`=0, `done`=0, `result`=0, `wb_rd_address`=0, `wb_reg_write`=0, iteration counter 0. The in-flight operation is discarded.
- FSM states: IDLE, CALC, FIX.
- IDLE, `start`=1 at an edge: capture `op`, `rd_address`, and operands.
  - Signed ops (DIV/REM): store absolute values of both operands, plus quotient sign = sign(rs1) XOR sign(rs2) and remainder sign = sign(rs1).
  - Divisor == 0: next state IDLE, `done`=1. `result` = all ones for DIV/DIVU; `result` = rs1_data unchanged for REM/REMU.
  - Signed overflow (DIV/REM, rs1 = 0x8000_0000_0000_0000, rs2 = all ones): next state IDLE, `done`=1. `result` = rs1 for DIV; `result` = 0 for REM.
  - Otherwise: next state CALC, counter = 64.
- CALC: radix-2 restoring step, one quotient bit per cycle.
  - Shift {rem, quo} left one bit.
  - If rem ≥ divisor: rem -= divisor and set quo[0].
  - Decrement counter; at counter = 1, next state FIX.
  - Remainder register is XLEN+1 bits wide to hold the shifted-out bit.
- FIX: select quotient or remainder by `op[1]`. For signed ops, negate per the stored sign (two's complement, XLEN-bit wrap). Register into `result`, set `done`=1, next state IDLE.
- `busy` = (state != IDLE).
- `start` while `busy`=1: ignored, with no effect on the operation in flight.
- `done` is a single-cycle registered pulse. It returns to 0 on the next edge unless a new 1-cycle special-case completion occurs.

## Timing
- Let E0 be the edge at which `start` is accepted.
- Normal path:
  - `busy`=1 from E0 through E65; CALC occupies edges E1..E64, FIX is E65.
  - At E65: `busy`=0, `done`=1, and `result`/`wb_rd_address` are valid.
  - Latency is 65 cycles, start to done.
- Special cases (divide by zero, signed overflow): `busy` stays 0. `done`=1 and `result` are valid after E0. Latency is 1 cycle.
- Back-to-back: `start` is accepted at the edge ending the `done` cycle. Throughput is one operation per 66 cycles (normal path) or one per cycle (special cases).
- `result` and `wb_rd_address` change only at completion edges. They are stable while `busy`=1.
- Operand inputs are don't-care after E0.

## Test plan
- DIVU 100/7: `start` pulse → `busy` high for 65 cycles, then `done` pulse, `result`=14, `wb_rd_address`=captured 5; repeat with REMU → `result`=2.
- DIV -100/7 → `result`=0xFFFF_FFFF_FFFF_FFF2 (-14); REM -100/7 → `result`=0xFFFF_FFFF_FFFF_FFFE (-2); DIV 100/-7 → -14; REM 100/-7 → 2.
- Divide by zero: DIVU 5/0 → `done` one cycle after start, `busy` never high, `result`=0xFFFF_FFFF_FFFF_FFFF; REM 5/0 → `result`=5.
- Signed overflow: DIV 0x8000_0000_0000_0000 / -1 → `result`=0x8000_0000_0000_0000 after 1 cycle; REM → `result`=0.
- Robustness:
  - Pulse `start` (DIVU 9/3) at cycle 10 of a running DIVU 1000/10 → ignored; only `result`=100 is produced.
  - Assert `reset_n`=0 at cycle 30 of a division → `busy`=`done`=`result`=0 immediately (async).
  - After release, DIVU 9/3 → `result`=3 after 65 cycles.
- Back-to-back: assert DIVU 0xFFFF_FFFF_FFFF_FFFF/1 in the `done` cycle of the prior operation → accepted; next `done` 65 cycles later with `result`=all ones; the prior `result` stays held until then.
